demut1_16_seq: RTL



---
 rtl/demut1_16_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/demut1_16_seq.sv
// ---------------------------------------------------------------------------
// demut1_16_seq
//
// Sequential 1-to-WIDTH demultiplexer / deserializer. Each accepted serial
// bit is steered into word position `count` (LSB first), and the select
// auto-increments. After WIDTH accepted bits, the assembled word is offered
// on a valid/ready output port. This block reconstructs the word sent by an
// upstream mux-based serializer that walks its select 0..WIDTH-1.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   din        in   1      serial data bit
//   din_valid  in   1      din is accepted on this clock edge
//   sync       in   1      frame restart, realigns the select to position 0
//   out        out  WIDTH  assembled word, stable while out_valid=1
//   out_valid  out  1      out holds an unconsumed word
//   out_ready  in   1      consumer takes out when out_valid=1
//   overrun    out  1      sticky: a completed word was dropped
//   count      out  CNT_W  next bit position to be written
// ---------------------------------------------------------------------------
module demut1_16_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    // State registers
    logic [WIDTH-1:0] r_asm;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_overrun;

    // Next-state values
    logic [WIDTH-1:0] w_asm_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_out_valid_nxt;
    logic             w_overrun_nxt;
    logic [WIDTH-1:0] w_word;

    // Next-state computation for assembly, select and output port
    always_comb begin
        w_asm_nxt       = r_asm;
        w_count_nxt     = r_count;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        w_overrun_nxt   = r_overrun;

        // Completed word: the final bit comes straight from din so the word
        // is available on the same edge that samples it.
        w_word            = r_asm;
        w_word[WIDTH-1]   = din;

        // Consume; a completion below may re-assert out_valid this cycle.
        if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end else begin
            w_out_valid_nxt = r_out_valid;
        end

        if (sync) begin
            // Realign: the partial frame is dropped without flagging overrun,
            // and no completion is possible in a sync cycle.
            w_asm_nxt = WORD_ZERO;
            if (din_valid) begin
                w_asm_nxt[0] = din;
                w_count_nxt  = CNT_ONE;
            end else begin
                w_count_nxt  = CNT_ZERO;
            end
        end else if (din_valid) begin
            if (r_count == CNT_LAST) begin
                w_asm_nxt   = WORD_ZERO;
                w_count_nxt = CNT_ZERO;
                // Load only if the output slot is free or being freed now.
                if (!r_out_valid || out_ready) begin
                    w_out_nxt       = w_word;
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_overrun_nxt   = 1'b1;
                end
            end else begin
                w_asm_nxt[r_count] = din;
                w_count_nxt        = r_count + CNT_ONE;
            end
        end else begin
            w_asm_nxt   = r_asm;
            w_count_nxt = r_count;
        end
    end

    // State update with synchronous reset overriding all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm       <= WORD_ZERO;
            r_count     <= CNT_ZERO;
            r_out       <= WORD_ZERO;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_asm       <= w_asm_nxt;
            r_count     <= w_count_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign count     = r_count;

endmodule
